// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes one asynchronous, bouncy input and debounces it
// with a 4-state FSM. It produces a clean registered level plus registered
// single-cycle rise/fall pulses, and a busy flag while a change is pending.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_btn_out;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Synchronizer chain: shift the raw input through SYNC_STAGES flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Debounce FSM: accept a level change only after DEBOUNCE_CYCLES equal
  // synced samples; pulses default low and are set only on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_LOW;
      r_cnt     <= '0;
      r_btn_out <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        S_LOW: begin
          if (w_synced) begin
            r_state <= S_WAIT_HIGH;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        S_WAIT_HIGH: begin
          if (!w_synced) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= S_HIGH;
            r_btn_out <= 1'b1;
            r_rise    <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!w_synced) begin
            r_state <= S_WAIT_LOW;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        S_WAIT_LOW: begin
          if (w_synced) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= S_LOW;
            r_btn_out <= 1'b0;
            r_fall    <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy    = (r_state == S_WAIT_HIGH) || (r_state == S_WAIT_LOW);
  assign btn_out = r_btn_out;
  assign rise    = r_rise;
  assign fall    = r_fall;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Stimulus pushes expected pulses (kind, edge number, level); a monitor pops
// and compares whenever the DUT emits rise or fall.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic btn_out;
  logic rise;
  logic fall;
  logic busy;

  typedef struct {
    logic is_rise;
    int   edge_no;
    logic lvl;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fails  = 0;

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_in  (btn_in),
    .btn_out (btn_out),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  // Drive inputs for one edge, then return at the following negedge.
  task automatic run_edge(input logic b, input logic r);
    btn_in = b;
    rst_n  = r;
    @(negedge clk);
  endtask

  // Clean transition to lvl, held for hold edges; pulse expected at edge 5.
  task automatic transition(input string name, input logic lvl, input int hold);
    int e0;
    e0 = edge_cnt + 1;
    q.push_back('{is_rise: lvl, edge_no: e0 + 5, lvl: lvl});
    for (int k = 0; k < hold; k++) begin
      run_edge(lvl, 1'b1);
      check({name, "_busy"}, int'(busy), int'(k >= 2 && k <= 4));
      check({name, "_level"}, int'(btn_out), int'(k >= 5 ? lvl : !lvl));
    end
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rise === 1'b1 || fall === 1'b1) begin
      check("pulse_exclusive", int'(rise && fall), 0);
      if (q.size() == 0) begin
        check("unexpected_pulse", int'(rise), -1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_kind_rise", int'(rise), int'(e.is_rise));
        check("pulse_edge", edge_cnt, e.edge_no);
        check("pulse_level", int'(btn_out), int'(e.lvl));
      end
    end
  end

  initial begin
    int e0;

    // 1. Reset with btn_in high, then release: treated as a press.
    for (int k = 0; k < 3; k++) run_edge(1'b1, 1'b0);
    check("rst_btn_out", int'(btn_out), 0);
    check("rst_rise", int'(rise), 0);
    check("rst_fall", int'(fall), 0);
    check("rst_busy", int'(busy), 0);
    transition("t1_press", 1'b1, 10);

    // 5. Release from debounced high.
    transition("t5_release", 1'b0, 10);

    // 2. Clean press, then release back to low.
    transition("t2_press", 1'b1, 10);
    transition("t2_release", 1'b0, 10);

    // 3. Glitch: three cycles high is one short of acceptance.
    for (int k = 0; k < 12; k++) begin
      run_edge(k < 3, 1'b1);
      check("t3_busy", int'(busy), int'(k >= 2 && k <= 4));
      check("t3_level", int'(btn_out), 0);
    end

    // 4. Bounce 1,0,1,0,1,0 then steady 1: one rise, 5 edges after edge 6.
    e0 = edge_cnt + 1;
    q.push_back('{is_rise: 1'b1, edge_no: e0 + 11, lvl: 1'b1});
    for (int k = 0; k < 18; k++) begin
      run_edge((k >= 6) ? 1'b1 : ((k % 2) == 0), 1'b1);
      check("t4_level", int'(btn_out), int'(k >= 11));
    end
    transition("t4_release", 1'b0, 10);

    // 6. Reset in the middle of a pending press.
    for (int k = 0; k < 3; k++) run_edge(1'b1, 1'b1);
    check("t6_busy_wait", int'(busy), 1);
    run_edge(1'b0, 1'b0);
    check("t6_busy_rst", int'(busy), 0);
    check("t6_level_rst", int'(btn_out), 0);
    check("t6_rise_rst", int'(rise), 0);
    run_edge(1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      run_edge(1'b0, 1'b1);
      check("t6_busy_after", int'(busy), 0);
      check("t6_level_after", int'(btn_out), 0);
    end

    // Drain: every expected pulse must have been seen within the budget.
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    check("pending_pulses", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
